// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS control tokens, decoder FSM states and the 10b->8b data decode.
package tmds_pkg;

  localparam logic [9:0] TOK_00 = 10'h354;
  localparam logic [9:0] TOK_01 = 10'h0AB;
  localparam logic [9:0] TOK_10 = 10'h154;
  localparam logic [9:0] TOK_11 = 10'h2AB;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // bit9 undoes the DC-balance inversion, bit8 selects XOR or XNOR chaining
  function automatic logic [7:0] tmds_10to8(input logic [9:0] sym);
    logic [7:0] e;
    logic [7:0] q;
    e    = sym[9] ? ~sym[7:0] : sym[7:0];
    q[0] = e[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = sym[8] ? (e[i] ^ e[i-1]) : ~(e[i] ^ e[i-1]);
    end
    return q;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// rtl/tmds_symbol_decode.sv - combinational decode of one aligned 10-bit TMDS symbol.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] i_sym,
  output logic       o_is_ctrl,
  output logic [1:0] o_ctrl,
  output logic [7:0] o_data
);

  always_comb begin
    o_is_ctrl = 1'b1;
    o_ctrl    = 2'b00;
    case (i_sym)
      TOK_00:  o_ctrl = 2'b00;
      TOK_01:  o_ctrl = 2'b01;
      TOK_10:  o_ctrl = 2'b10;
      TOK_11:  o_ctrl = 2'b11;
      default: o_is_ctrl = 1'b0;
    endcase
  end

  assign o_data = tmds_10to8(i_sym);

endmodule

// File: rtl/tmds_channel_decoder.sv
// rtl/tmds_channel_decoder.sv - TMDS channel bitslip alignment, lock FSM and symbol decode.
// Optional TMDS_DEC_STATS_EN adds saturating bitslip and lock-loss counters.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN_MIN  = 8,
  parameter int SEARCH_CYCLES = 2048,
  parameter int LOSS_CYCLES   = 4096
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic [9:0]  raw_in,
  output logic        o_de,
  output logic [1:0]  o_ctrl,
  output logic [7:0]  o_data,
  output logic        o_locked,
  output logic [3:0]  o_offset
`ifdef TMDS_DEC_STATS_EN
  ,
  output logic [15:0] o_slip_cnt,
  output logic [15:0] o_loss_cnt
`endif
);

  localparam int RUN_W = $clog2(CTRL_RUN_MIN + 1);
  localparam int TMR_W = $clog2((LOSS_CYCLES > SEARCH_CYCLES) ? LOSS_CYCLES : SEARCH_CYCLES);

  logic [9:0]       r_raw_prev;
  logic [9:0]       r_window;
  state_t           r_state;
  logic [3:0]       r_offset;
  logic [TMR_W-1:0] r_tmr;
  logic [RUN_W-1:0] r_run_cnt;
  logic             r_de;
  logic [1:0]       r_ctrl;
  logic [7:0]       r_data;

  logic [19:0]      w_hist;
  logic             w_is_ctrl;
  logic [1:0]       w_ctrl;
  logic [7:0]       w_data;
  logic             w_run_hit;
  state_t           w_state_n;
  logic [3:0]       w_offset_n;
  logic [TMR_W-1:0] w_tmr_n;
  logic [RUN_W-1:0] w_run_n;
  logic             w_step;
  logic             w_loss;

  // bit0 is earliest on the wire, so the older word sits in the low half
  assign w_hist = {raw_in, r_raw_prev};

  tmds_symbol_decode u_sym_dec (
    .i_sym     (r_window),
    .o_is_ctrl (w_is_ctrl),
    .o_ctrl    (w_ctrl),
    .o_data    (w_data)
  );

  assign w_run_hit = w_is_ctrl && (r_run_cnt == RUN_W'(CTRL_RUN_MIN - 1));

  always_comb begin
    w_state_n  = r_state;
    w_offset_n = r_offset;
    w_tmr_n    = r_tmr + 1'b1;
    w_step     = 1'b0;
    w_loss     = 1'b0;
    if (!w_is_ctrl) begin
      w_run_n = '0;
    end else if (r_run_cnt != RUN_W'(CTRL_RUN_MIN)) begin
      w_run_n = r_run_cnt + 1'b1;
    end else begin
      w_run_n = r_run_cnt;
    end
    case (r_state)
      ST_SEARCH: begin
        if (w_run_hit) begin
          w_state_n = ST_LOCKED;
          w_tmr_n   = '0;
        end else if (r_tmr == TMR_W'(SEARCH_CYCLES - 1)) begin
          w_step  = 1'b1;
          w_tmr_n = '0;
          w_run_n = '0;
        end
      end
      default: begin
        if (w_run_hit) begin
          w_tmr_n = '0;
        end else if (r_tmr == TMR_W'(LOSS_CYCLES - 1)) begin
          w_state_n = ST_SEARCH;
          w_step    = 1'b1;
          w_loss    = 1'b1;
          w_tmr_n   = '0;
          w_run_n   = '0;
        end
      end
    endcase
    if (w_step) begin
      w_offset_n = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
    end
  end

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      r_raw_prev <= '0;
      r_window   <= '0;
      r_state    <= ST_SEARCH;
      r_offset   <= '0;
      r_tmr      <= '0;
      r_run_cnt  <= '0;
      r_de       <= 1'b0;
      r_ctrl     <= 2'b00;
      r_data     <= 8'h00;
    end else begin
      r_raw_prev <= raw_in;
      r_window   <= w_hist[r_offset +: 10];
      r_state    <= w_state_n;
      r_offset   <= w_offset_n;
      r_tmr      <= w_tmr_n;
      r_run_cnt  <= w_run_n;
      // gate on next state so outputs and o_locked change on the same edge
      if (w_state_n == ST_LOCKED) begin
        r_de   <= ~w_is_ctrl;
        r_data <= w_is_ctrl ? 8'h00 : w_data;
        if (w_is_ctrl) begin
          r_ctrl <= w_ctrl;
        end
      end else begin
        r_de   <= 1'b0;
        r_ctrl <= 2'b00;
        r_data <= 8'h00;
      end
    end
  end

  assign o_de     = r_de;
  assign o_ctrl   = r_ctrl;
  assign o_data   = r_data;
  assign o_locked = (r_state == ST_LOCKED);
  assign o_offset = r_offset;

`ifdef TMDS_DEC_STATS_EN
  logic [15:0] r_slip_cnt;
  logic [15:0] r_loss_cnt;

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      r_slip_cnt <= '0;
      r_loss_cnt <= '0;
    end else begin
      if (w_step && (r_slip_cnt != 16'hFFFF)) begin
        r_slip_cnt <= r_slip_cnt + 16'd1;
      end
      if (w_loss && (r_loss_cnt != 16'hFFFF)) begin
        r_loss_cnt <= r_loss_cnt + 16'd1;
      end
    end
  end

  assign o_slip_cnt = r_slip_cnt;
  assign o_loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb/tb_tmds_channel_decoder.sv - self-checking bench for tmds_channel_decoder.
module tb_tmds_channel_decoder;

  localparam int CTRL_RUN_MIN  = 8;
  localparam int SEARCH_CYCLES = 2048;
  localparam int LOSS_CYCLES   = 4096;
  localparam int LINE          = 800;
  localparam int ACTIVE        = 640;

  logic       pix_clk = 1'b0;
  logic       rst     = 1'b1;
  logic [9:0] raw_in  = '0;
  logic       o_de;
  logic [1:0] o_ctrl;
  logic [7:0] o_data;
  logic       o_locked;
  logic [3:0] o_offset;
`ifdef TMDS_DEC_STATS_EN
  logic [15:0] o_slip_cnt;
  logic [15:0] o_loss_cnt;
`endif

  tmds_channel_decoder #(
    .CTRL_RUN_MIN  (CTRL_RUN_MIN),
    .SEARCH_CYCLES (SEARCH_CYCLES),
    .LOSS_CYCLES   (LOSS_CYCLES)
  ) dut (
    .pix_clk  (pix_clk),
    .rst      (rst),
    .raw_in   (raw_in),
    .o_de     (o_de),
    .o_ctrl   (o_ctrl),
    .o_data   (o_data),
    .o_locked (o_locked),
    .o_offset (o_offset)
`ifdef TMDS_DEC_STATS_EN
    ,
    .o_slip_cnt (o_slip_cnt),
    .o_loss_cnt (o_loss_cnt)
`endif
  );

  always #5 pix_clk = ~pix_clk;

  int         errors = 0;
  int         checks = 0;
  bit         bitq[$];
  bit         exp_is_ctrl [0:65535];
  logic [7:0] exp_val     [0:65535];
  int         cyc = 0;
  int         px  = 0;
  logic [1:0] hold_ctrl = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  function automatic bit is_tok(input logic [9:0] s);
    return (s == 10'h354) || (s == 10'h0AB) || (s == 10'h154) || (s == 10'h2AB);
  endfunction

  // transmit-side encoder: XOR/XNOR chain then optional inversion
  function automatic logic [9:0] enc(input logic [7:0] d, input bit use_xor, input bit inv);
    logic [7:0] qm;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xor ? (qm[i-1] ^ d[i]) : ~(qm[i-1] ^ d[i]);
    end
    return {inv, use_xor, inv ? ~qm : qm};
  endfunction

  task automatic push_sym(input logic [9:0] s, input bit ctl, input logic [7:0] v);
    for (int i = 0; i < 10; i++) bitq.push_back(s[i]);
    exp_is_ctrl[cyc[15:0]] = ctl;
    exp_val[cyc[15:0]]     = v;
  endtask

  task automatic push_tok(input logic [1:0] c);
    push_sym(tok(c), 1'b1, {6'd0, c});
  endtask

  task automatic push_pix(input logic [7:0] d, input bit use_xor, input bit inv);
    push_sym(enc(d, use_xor, inv), 1'b0, d);
  endtask

  task automatic push_rand_pix();
    logic [7:0] d;
    bit         x;
    bit         inv;
    do begin
      d   = 8'($urandom_range(0, 255));
      x   = 1'($urandom_range(0, 1));
      inv = 1'($urandom_range(0, 1));
    end while (is_tok(enc(d, x, inv)));
    push_pix(d, x, inv);
  endtask

  task automatic tick();
    logic [9:0] w;
    int         idx;
    for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
    raw_in = w;
    @(posedge pix_clk);
    #1;
    if (o_locked === 1'b1) begin
      if (cyc >= 2) begin
        idx = (cyc - 2) & 16'hFFFF;
        if (exp_is_ctrl[idx]) begin
          hold_ctrl = exp_val[idx][1:0];
          chk("token", {o_de, o_ctrl, o_data}, {1'b0, hold_ctrl, 8'h00});
        end else begin
          chk("pixel", {o_de, o_ctrl, o_data}, {1'b1, hold_ctrl, exp_val[idx]});
        end
      end
    end else begin
      chk("blank", {o_de, o_ctrl, o_data}, 32'h0);
    end
    cyc++;
  endtask

  task automatic push_video();
    if (px < ACTIVE) push_rand_pix();
    else push_tok((px >= 656 && px < 752) ? 2'b01 : 2'b00);
    px = (px + 1) % LINE;
  endtask

  task automatic run_video(input int n);
    for (int k = 0; k < n; k++) begin
      push_video();
      tick();
    end
  endtask

  task automatic start_stream(input int shift);
    bitq.delete();
    for (int i = 0; i < shift; i++) bitq.push_back(1'b0);
    px = 0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    raw_in = '0;
    @(posedge pix_clk);
    #1;
    chk("rst_locked", o_locked, 0);
    chk("rst_offset", o_offset, 0);
    chk("rst_outputs", {o_de, o_ctrl, o_data}, 0);
`ifdef TMDS_DEC_STATS_EN
    chk("rst_slip", o_slip_cnt, 0);
    chk("rst_loss", o_loss_cnt, 0);
`endif
    rst       = 1'b0;
    cyc       = 0;
    hold_ctrl = 2'b00;
  endtask

  initial begin
    bit got;

    // aligned stream: lock exactly 10 symbols into the first hblank
    do_reset();
    start_stream(0);
    run_video(ACTIVE + CTRL_RUN_MIN + 1);
    chk("align0_prelock", o_locked, 0);
    run_video(1);
    chk("align0_lock", o_locked, 1);
    chk("align0_offset", o_offset, 0);
    run_video(2 * LINE);

    // all four tokens and 0xA5 in every encoding
    push_tok(2'b00); tick();
    push_tok(2'b01); tick();
    push_tok(2'b10); tick();
    push_tok(2'b11); tick();
    push_pix(8'hA5, 1'b0, 1'b0); tick();
    push_pix(8'hA5, 1'b1, 1'b1); tick();
    push_pix(8'hA5, 1'b0, 1'b1); tick();
    push_pix(8'hA5, 1'b1, 1'b0); tick();
    push_tok(2'b01); tick();
    push_tok(2'b00); tick();
    run_video(4);

    // constant 3FF starves the token run until lock is dropped
    got = 1'b0;
    for (int k = 0; k < LOSS_CYCLES + LINE; k++) begin
      push_pix(8'h00, 1'b1, 1'b1);
      tick();
      if (k == LOSS_CYCLES / 2) chk("loss_still_locked", o_locked, 1);
      if (o_locked === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    chk("loss_dropped", got, 1);
    chk("loss_offset", o_offset, 1);
`ifdef TMDS_DEC_STATS_EN
    chk("loss_cnt", o_loss_cnt, 1);
    chk("loss_slip_cnt", o_slip_cnt, 1);
`endif
    for (int k = 0; k < 20; k++) begin
      push_pix(8'h00, 1'b1, 1'b1);
      tick();
    end

    // stream delayed by 7 bits: one step per SEARCH_CYCLES, lock at 7
    do_reset();
    start_stream(7);
    for (int s = 1; s <= 7; s++) begin
      run_video((SEARCH_CYCLES * s - 1) - cyc);
      chk("step_before", o_offset, s - 1);
      run_video(1);
      chk("step_after", o_offset, s);
    end
    got = 1'b0;
    for (int k = 0; k < 2 * LINE; k++) begin
      run_video(1);
      if (o_locked === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("shift_lock", got, 1);
    chk("shift_offset", o_offset, 7);
`ifdef TMDS_DEC_STATS_EN
    chk("shift_slip_cnt", o_slip_cnt, 7);
`endif
    run_video(2 * LINE);

    // token run completes on the very cycle the search timer expires
    do_reset();
    start_stream(0);
    for (int k = 0; k < SEARCH_CYCLES - CTRL_RUN_MIN - 2; k++) begin
      push_pix(8'h00, 1'b1, 1'b1);
      tick();
    end
    for (int k = 0; k < CTRL_RUN_MIN + 1; k++) begin
      push_tok(2'b10);
      tick();
    end
    chk("tie_prelock", o_locked, 0);
    chk("tie_pre_offset", o_offset, 0);
    push_tok(2'b10);
    tick();
    chk("tie_lock", o_locked, 1);
    chk("tie_offset", o_offset, 0);
    for (int k = 0; k < 4; k++) begin
      push_tok(2'b11);
      tick();
    end

    // reset while locked
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
